// File: rtl/popcount_stream_acc_pkg.sv
// Shared types and helpers for the popcount stream accumulator.
//   clog2 / count_w / group_w : width helpers for per-beat and per-group counts
//   mode_e                    : per-beat vs frame-accumulate mode
//   sat_add / add_ovf         : saturating add at a given width, plus overflow flag
package popcount_stream_pkg;

  localparam int unsigned GROUPS = 4;

  typedef enum logic {
    MODE_BEAT  = 1'b0,
    MODE_FRAME = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed to hold a count of 0..n
  function automatic int unsigned count_w(input int unsigned n);
    return clog2(n + 1);
  endfunction

  function automatic int unsigned group_w(input int unsigned n);
    return n / GROUPS;
  endfunction

  // min(a + b, 2^w - 1); w must be <= 64
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (65'd1 << w) - 65'd1;
    return (s > m) ? m[63:0] : s[63:0];
  endfunction

  function automatic logic add_ovf(input logic [63:0] a, input logic [63:0] b,
                                   input int unsigned w);
    logic [64:0] s;
    logic [64:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (65'd1 << w) - 65'd1;
    return s > m;
  endfunction

endpackage

// File: rtl/popcount_stream_acc_if.sv
// Valid/ready stream bundle for popcount_stream_acc.
//   in_*  : input beat (valid, ready, data, last, mode)
//   out_* : result (valid, ready, count, beats, sat)
// slave = the accumulator, master = producer/consumer side.
interface popcount_stream_acc_if #(
  parameter int unsigned N      = 64,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned BEAT_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_data;
  logic              in_last;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_count;
  logic [BEAT_W-1:0] out_beats;
  logic              out_sat;

  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_beats, out_sat
  );

  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_beats, out_sat
  );
endinterface

// File: rtl/popcount_stream_acc_group.sv
// Combinational population count of a W-bit slice.
//   i_data  : W-bit slice
//   o_count : number of set bits, clog2(W+1) wide
module popcount_group
  import popcount_stream_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned OW = count_w(W)
) (
  input  logic [W-1:0]  i_data,
  output logic [OW-1:0] o_count
);
  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < W; i++) o_count += OW'(i_data[i]);
  end
endmodule

// File: rtl/popcount_stream_acc.sv
// Pipelined popcount with per-beat or frame-accumulate output.
//   clk, rst : clock, synchronous active-high reset
//   st       : stream bundle (slave side), see popcount_stream_acc_if
// Stages: S1 group partials, S2 per-beat sum, S3 output/accumulator.
// The whole pipeline advances only when the output slot is free or being taken.
module popcount_stream_acc
  import popcount_stream_pkg::*;
#(
  parameter int unsigned N      = 64,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned BEAT_W = 8,
  parameter int unsigned CW     = count_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  popcount_stream_acc_if.slave st
);
  localparam int unsigned GW  = group_w(N);
  localparam int unsigned GCW = count_w(GW);

  logic              w_adv;
  logic [GCW-1:0]    w_part [GROUPS];
  logic [CW-1:0]     w_sum;
  logic [ACC_W-1:0]  w_acc_next;
  logic              w_sat_next;
  logic [BEAT_W-1:0] w_beats_next;

  logic              r_s1_valid, r_s1_last;
  mode_e             r_s1_mode;
  logic [GCW-1:0]    r_s1_part [GROUPS];
  logic              r_s2_valid, r_s2_last;
  mode_e             r_s2_mode;
  logic [CW-1:0]     r_s2_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic              r_sat;
  logic [BEAT_W-1:0] r_beats;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_count;
  logic [BEAT_W-1:0] r_out_beats;
  logic              r_out_sat;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    popcount_group #(.W(GW), .OW(GCW)) u_grp (
      .i_data (st.in_data[g*GW +: GW]),
      .o_count(w_part[g])
    );
  end

  assign w_adv = !r_out_valid || st.out_ready;

  always_comb begin
    w_sum = '0;
    for (int unsigned g = 0; g < GROUPS; g++) w_sum += CW'(r_s1_part[g]);
    w_acc_next   = ACC_W'(sat_add(64'(r_acc), 64'(r_s2_cnt), ACC_W));
    w_sat_next   = r_sat | add_ovf(64'(r_acc), 64'(r_s2_cnt), ACC_W);
    w_beats_next = BEAT_W'(sat_add(64'(r_beats), 64'd1, BEAT_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_mode   <= MODE_BEAT;
      r_s1_part   <= '{default: '0};
      r_s2_valid  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_mode   <= MODE_BEAT;
      r_s2_cnt    <= '0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_beats     <= '0;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_beats <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= st.in_valid;
      r_s1_last   <= st.in_last;
      r_s1_mode   <= mode_e'(st.in_mode);
      r_s1_part   <= w_part;
      r_s2_valid  <= r_s1_valid;
      r_s2_last   <= r_s1_last;
      r_s2_mode   <= r_s1_mode;
      r_s2_cnt    <= w_sum;
      r_out_valid <= 1'b0;
      if (r_s2_valid) begin
        if (r_s2_mode == MODE_BEAT) begin
          // Frame state is left alone so single beats can interleave a frame
          r_out_valid <= 1'b1;
          r_out_count <= ACC_W'(r_s2_cnt);
          r_out_beats <= BEAT_W'(1);
          r_out_sat   <= 1'b0;
        end else if (r_s2_last) begin
          r_out_valid <= 1'b1;
          r_out_count <= w_acc_next;
          r_out_beats <= w_beats_next;
          r_out_sat   <= w_sat_next;
          r_acc       <= '0;
          r_sat       <= 1'b0;
          r_beats     <= '0;
        end else begin
          r_acc       <= w_acc_next;
          r_sat       <= w_sat_next;
          r_beats     <= w_beats_next;
        end
      end
    end
  end

  assign st.in_ready  = w_adv;
  assign st.out_valid = r_out_valid;
  assign st.out_count = r_out_count;
  assign st.out_beats = r_out_beats;
  assign st.out_sat   = r_out_sat;
endmodule

// File: tb/tb_popcount_stream_acc.sv
module tb_popcount_stream_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        t_valid  = 1'b0;
  logic        t_last   = 1'b0;
  logic        t_mode   = 1'b0;
  logic        t_oready = 1'b1;
  logic [63:0] t_data   = '0;

  popcount_stream_acc_if #(.N(64), .ACC_W(16), .BEAT_W(8)) bus_a ();
  popcount_stream_acc_if #(.N(64), .ACC_W(8),  .BEAT_W(8)) bus_b ();

  assign bus_a.in_valid  = t_valid;
  assign bus_a.in_data   = t_data;
  assign bus_a.in_last   = t_last;
  assign bus_a.in_mode   = t_mode;
  assign bus_a.out_ready = t_oready;
  assign bus_b.in_valid  = t_valid;
  assign bus_b.in_data   = t_data;
  assign bus_b.in_last   = t_last;
  assign bus_b.in_mode   = t_mode;
  assign bus_b.out_ready = t_oready;

  popcount_stream_acc #(.N(64), .ACC_W(16), .BEAT_W(8)) dut_a (
    .clk(clk), .rst(rst), .st(bus_a.slave)
  );
  popcount_stream_acc #(.N(64), .ACC_W(8), .BEAT_W(8)) dut_b (
    .clk(clk), .rst(rst), .st(bus_b.slave)
  );

  typedef struct {
    int unsigned cnt_a;
    int unsigned sat_a;
    int unsigned cnt_b;
    int unsigned sat_b;
    int unsigned beats;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int unsigned n_out = 0;
  int unsigned m_acc_a = 0, m_acc_b = 0, m_sat_a = 0, m_sat_b = 0, m_beats = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_accept();
    int unsigned c;
    exp_t e;
    c = $countones(t_data);
    if (!t_mode) begin
      e = '{cnt_a: c, sat_a: 0, cnt_b: c, sat_b: 0, beats: 1};
      sb.push_back(e);
    end else begin
      if (m_acc_a + c > 65535) begin m_acc_a = 65535; m_sat_a = 1; end
      else m_acc_a = m_acc_a + c;
      if (m_acc_b + c > 255) begin m_acc_b = 255; m_sat_b = 1; end
      else m_acc_b = m_acc_b + c;
      m_beats = (m_beats >= 255) ? 255 : m_beats + 1;
      if (t_last) begin
        e = '{cnt_a: m_acc_a, sat_a: m_sat_a, cnt_b: m_acc_b, sat_b: m_sat_b, beats: m_beats};
        sb.push_back(e);
        m_acc_a = 0; m_acc_b = 0; m_sat_a = 0; m_sat_b = 0; m_beats = 0;
      end
    end
  endtask

  // Scoreboard: push on accepted beats, pop on taken results
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      m_acc_a = 0; m_acc_b = 0; m_sat_a = 0; m_sat_b = 0; m_beats = 0;
    end else begin
      if (t_valid && bus_a.in_ready) model_accept();
      if (bus_a.out_valid && t_oready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("count_a", bus_a.out_count, e.cnt_a);
          chk("beats_a", bus_a.out_beats, e.beats);
          chk("sat_a",   bus_a.out_sat,   e.sat_a);
          chk("valid_b", bus_b.out_valid, 1);
          chk("count_b", bus_b.out_count, e.cnt_b);
          chk("beats_b", bus_b.out_beats, e.beats);
          chk("sat_b",   bus_b.out_sat,   e.sat_b);
        end
      end
    end
  end

  // Call just after a posedge; returns just after the accepting edge
  task automatic send(input logic [63:0] d, input logic mode, input logic last);
    int unsigned n;
    t_valid = 1'b1; t_data = d; t_mode = mode; t_last = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus_a.in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    t_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; t_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_out_count", bus_a.out_count, 0);
    chk("rst_out_beats", bus_a.out_beats, 0);
    chk("rst_out_sat",   bus_a.out_sat,   0);
    chk("rst_in_ready",  bus_a.in_ready,  1);
    @(posedge clk); #1;

    // Single all-ones beat, latency check
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk); chk("lat_c1", bus_a.out_valid, 0);
    @(negedge clk); chk("lat_c2", bus_a.out_valid, 0);
    @(negedge clk); chk("lat_c3", bus_a.out_valid, 1);
    idle(3);

    // Three-beat frame -> 97
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    send(64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
    send(64'h0000_0000_0000_0001, 1'b1, 1'b1);
    idle(6);

    // Five all-ones: saturates the 8-bit accumulator, then a fresh frame
    for (int i = 0; i < 5; i++) send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, i == 4);
    send(64'h0000_0000_0000_000F, 1'b1, 1'b1);
    idle(6);

    // Interleave a single beat inside a frame
    send(64'h0000_0000_0000_03FF, 1'b1, 1'b0);
    send(64'h0000_0000_0000_001F, 1'b0, 1'b0);
    send(64'h0000_0000_0000_007F, 1'b1, 1'b1);
    idle(6);

    // Backpressure
    t_oready = 1'b0;
    send(64'h1, 1'b0, 1'b0);
    send(64'h3, 1'b0, 1'b0);
    send(64'h7, 1'b0, 1'b0);
    t_valid = 1'b1; t_data = 64'hF; t_mode = 1'b0; t_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready",  bus_a.in_ready,  0);
      chk("bp_out_valid", bus_a.out_valid, 1);
      chk("bp_out_count", bus_a.out_count, 1);
      chk("bp_out_beats", bus_a.out_beats, 1);
    end
    @(posedge clk); #1;
    t_oready = 1'b1;
    @(negedge clk); chk("bp_stream0", bus_a.out_valid, 1);
    @(posedge clk); #1;
    t_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); chk("bp_stream", bus_a.out_valid, 1);
    end
    idle(4);

    // Reset mid-frame, then a one-beat frame
    send(64'hFF, 1'b1, 1'b0);
    send(64'hFF, 1'b1, 1'b0);
    do_reset();
    send(64'h3, 1'b1, 1'b1);
    idle(8);

    chk("drain", sb.size(), 0);
    chk("n_outputs", n_out, 11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
